frame_config_loader: RTL and testbench
======================================

Name: frame_config_loader

Overview:
- Sequences configuration frames into one fabric column of tiles: switch matrices, RAM_IO and LUT tiles.
- Accepts a stream of 32-bit config words over a valid/ready handshake. Each frame is one header word followed by NumRows data words.
- Drives the column's FrameData bus and a one-cycle, one-hot FrameStrobe.
- Sits between the bitstream front end (UART/SPI config port) and the column's tile chain.

Parameters:
- NumRows, 4, tiles per column; sets the number of data words per frame.
- FrameBitsPerRow, 32, FrameData bits per tile row; fixed at 32, one word per row.
- MaxFramesPerCol, 20, number of FrameStrobe lines (frame addresses) per column.

Ports:
- CLK  in  1  fabric config clock; everything is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- cfg_data  in  32  header or data word.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- FrameData  out  NumRows*FrameBitsPerRow  frame payload; row r occupies bits [32r+31:32r].
- FrameStrobe  out  MaxFramesPerCol  one-hot write strobe to tile config latches.
- busy  out  1  high in any state other than IDLE.
- err_idx  out  1  sticky: a header had an out-of-range frame index.
- err_par  out  1  sticky parity error; constant 0 when the optional feature is off.
- frames_done  out  16  count of frames strobed; wraps 0xFFFF -> 0.

Behaviour:
- Reset: on CLK edge with RST=1, all outputs go to 0 and state goes to IDLE.
  - Applies mid-frame too: the partial frame is dropped and no strobe is issued.
- Transfer rule: a word transfers only on a cycle where cfg_valid and cfg_ready are both 1. cfg_data is ignored otherwise.
- Header format: bits [7:0] frame index idx; bit [31] parity (used only with the optional feature); bits [30:8] ignored.
- States:
  - IDLE: cfg_ready=1. On header transfer:
    - idx < MaxFramesPerCol -> LOAD, latch idx, word counter = 0.
    - otherwise -> DISCARD, set err_idx.
  - LOAD: cfg_ready=1.
    - Each transfer writes FrameData row[counter], row 0 first, then increments the counter.
    - The transfer with counter == NumRows-1 moves to STROBE.
  - DISCARD: cfg_ready=1. Consumes NumRows words, FrameData unchanged, then -> IDLE. No strobe.
  - STROBE: cfg_ready=0. FrameStrobe[idx]=1 for exactly this one cycle, frames_done += 1, then -> IDLE.
- Latency:
  - Last data word accepted at edge T.
  - FrameStrobe high during cycle T..T+1.
  - cfg_ready high again from edge T+1; the next header can transfer at edge T+2.
- FrameData stability: holds its value from the end of LOAD until the first data word of the next LOAD. It is stable throughout STROBE.
- FrameStrobe is registered, glitch-free, and never has more than one bit set.
- cfg_valid low mid-frame: the loader waits indefinitely with no timeout. State and counter are held.
- Error flags: err_idx and err_par clear only on RST.

Optional Feature:
- Macro: FRAME_CONFIG_LOADER_PARITY_EN.
- Enabled:
  - Accumulates XOR-reduction of all NumRows data words of a frame.
  - At the end of LOAD, if header bit31 != computed parity (even parity over the data), go to IDLE instead of STROBE and set err_par. frames_done is unchanged.
  - A good frame behaves exactly as without the macro.
- Disabled: header bit31 is ignored; err_par is tied to 0; there is no parity logic.

Decomposition:
- Package frame_config_loader_pkg:
  - state enum {IDLE, LOAD, DISCARD, STROBE};
  - header field constants HDR_IDX_LSB=0, HDR_IDX_MSB=7, HDR_PAR_BIT=31;
  - CFG_WORD_W=32.
- One sub-module, frame_parity_acc: a clear/accumulate XOR reducer, instantiated only under the macro.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, then header idx=3 followed by 4 words 0x11111111..0x44444444 -> FrameData = {0x44444444,0x33333333,0x22222222,0x11111111}. FrameStrobe = 0x00008 for exactly 1 cycle, 1 cycle after the last word. frames_done=1.
- Header idx=25 followed by 4 words -> all 4 words consumed, no strobe, err_idx=1, FrameData unchanged. A following valid frame idx=0 strobes bit 0.
- Header idx=7, then valid toggled 1,0,0,1 between data words -> strobe only after the 4th transfer. Counter holds through the gaps.
- Header idx=5, 2 data words, then RST=1 for 1 cycle -> no strobe, outputs 0. A new frame idx=5 loads correctly from row 0.
- Back-to-back frames idx=1 and idx=2 with cfg_valid held high -> cfg_ready=0 only in STROBE cycles. Strobes appear 0x2 then 0x4. frames_done=2.
- With PARITY_EN: words 0x1,0,0,0 and header bit31=0 -> err_par=1, no strobe. Same frame with bit31=1 -> strobe issued.

Source files
------------

// File: rtl/frame_config_loader_pkg.sv
// rtl/frame_config_loader_pkg.sv - shared types and header field positions for the frame config loader
package frame_config_loader_pkg;

    localparam int CFG_WORD_W  = 32;
    localparam int HDR_IDX_LSB = 0;
    localparam int HDR_IDX_MSB = 7;
    localparam int HDR_PAR_BIT = 31;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DISCARD,
        STROBE
    } state_t;

endpackage

// File: rtl/frame_parity_acc.sv
// rtl/frame_parity_acc.sv - clear/accumulate XOR reducer over config data words
module frame_parity_acc
    import frame_config_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [CFG_WORD_W-1:0] data,
    output logic                  parity,
    output logic                  parity_next
);

    // parity_next already folds in the word on the bus, so the final word can be judged on its own transfer
    assign parity_next = parity ^ (^data);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity_next;
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - sequences header+data config frames into one column; FRAME_CONFIG_LOADER_PARITY_EN adds frame parity checking
module frame_config_loader
    import frame_config_loader_pkg::*;
#(
    parameter int NumRows         = 4,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [CFG_WORD_W-1:0]               cfg_data,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                busy,
    output logic                                err_idx,
    output logic                                err_par,
    output logic [15:0]                         frames_done
);

    localparam int CntW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW = HDR_IDX_MSB - HDR_IDX_LSB + 1;

    state_t          state;
    state_t          state_next;
    logic [CntW-1:0] cnt;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] hdr_idx;
    logic            xfer;
    logic            hdr_ok;
    logic            last_word;
    logic            par_ok;

    assign hdr_idx   = cfg_data[HDR_IDX_MSB:HDR_IDX_LSB];
    assign hdr_ok    = int'(hdr_idx) < MaxFramesPerCol;
    assign last_word = (cnt == CntW'(NumRows - 1));
    assign cfg_ready = (state != STROBE);
    assign xfer      = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);

`ifdef FRAME_CONFIG_LOADER_PARITY_EN
    logic par_bit_q;
    logic par_acc;
    logic par_next;

    frame_parity_acc u_parity (
        .clk         (CLK),
        .rst         (RST),
        .clear       (state == IDLE && xfer),
        .en          (state == LOAD && xfer),
        .data        (cfg_data),
        .parity      (par_acc),
        .parity_next (par_next)
    );

    // even parity: header bit must equal the XOR of every data bit in the frame
    assign par_ok = (par_bit_q == par_next);
`else
    assign par_ok  = 1'b1;
    assign err_par = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer) state_next = hdr_ok ? LOAD : DISCARD;
            LOAD:    if (xfer && last_word) state_next = par_ok ? STROBE : IDLE;
            DISCARD: if (xfer && last_word) state_next = IDLE;
            STROBE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            idx_q       <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            err_idx     <= 1'b0;
            frames_done <= '0;
`ifdef FRAME_CONFIG_LOADER_PARITY_EN
            par_bit_q   <= 1'b0;
            err_par     <= 1'b0;
`endif
        end else begin
            FrameStrobe <= '0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cnt <= '0;
                        if (hdr_ok) begin
                            idx_q <= hdr_idx;
                        end else begin
                            err_idx <= 1'b1;
                        end
`ifdef FRAME_CONFIG_LOADER_PARITY_EN
                        par_bit_q <= cfg_data[HDR_PAR_BIT];
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        FrameData[cnt*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
                        cnt <= cnt + 1'b1;
                        // strobe is registered here so it is high for exactly the STROBE cycle
                        if (last_word) begin
                            if (par_ok) begin
                                FrameStrobe <= {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << idx_q;
                                frames_done <= frames_done + 16'd1;
                            end
`ifdef FRAME_CONFIG_LOADER_PARITY_EN
                            else begin
                                err_par <= 1'b1;
                            end
`endif
                        end
                    end
                end
                DISCARD: begin
                    if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// tb/tb_frame_config_loader.sv - table-driven, scoreboarded bench for frame_config_loader
module tb_frame_config_loader;

    localparam int MF = 20;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [127:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         err_idx;
    logic         err_par;
    logic [15:0]  frames_done;

    frame_config_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err_idx     (err_idx),
        .err_par     (err_par),
        .frames_done (frames_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0]  strobe;
        logic [127:0] fd;
        logic [15:0]  done;
        int           cycle;
    } sb_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] d [4];
        bit          load;
        logic [19:0] strobe;
        logic        err_idx;
    } vec_t;

    sb_t          sb_q[$];
    vec_t         tbl[7];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    bit           mon_en = 0;
    logic [127:0] m_fd;
    logic [15:0]  m_done;
    logic         m_err_par;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        sb_t e;
        if (mon_en) begin
            chk("ready_vs_strobe", {127'd0, cfg_ready}, {127'd0, FrameStrobe == 20'd0});
            if (FrameStrobe != 20'd0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", {108'd0, FrameStrobe}, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe", {108'd0, FrameStrobe}, {108'd0, e.strobe});
                    chk("strobe_cycle", 128'(cyc), 128'(e.cycle));
                    chk("strobe_framedata", FrameData, e.fd);
                    chk("strobe_frames_done", {112'd0, frames_done}, {112'd0, e.done});
                end
            end
        end
    end

    function automatic logic [31:0] mk_hdr(input logic [30:0] body, input logic [31:0] d [4]);
        return {^{d[0], d[1], d[2], d[3]}, body};
    endfunction

    task automatic send_word(input logic [31:0] w, output int xcyc);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(negedge CLK);
        while (!cfg_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 128'd0, 128'd1);
        @(posedge CLK);
        #1;
        xcyc = cyc;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d [4], input bit load,
                              input logic [19:0] strobe, input bit keep,
                              output int hdr_cyc, output int last_cyc);
        sb_t e;
        send_word(hdr, hdr_cyc);
        for (int i = 0; i < 4; i++) send_word(d[i], last_cyc);
        if (load) begin
            for (int i = 0; i < 4; i++) m_fd[32*i +: 32] = d[i];
        end
        if (strobe != 20'd0) begin
            m_done++;
            e.strobe = strobe;
            e.fd     = m_fd;
            e.done   = m_done;
            e.cycle  = last_cyc;
            sb_q.push_back(e);
        end
        if (!keep) cfg_valid = 1'b0;
    endtask

    task automatic settle_and_check(input string tag, input logic exp_err_idx);
        repeat (3) @(posedge CLK);
        #1;
        chk({tag, "_err_idx"}, {127'd0, err_idx}, {127'd0, exp_err_idx});
        chk({tag, "_framedata"}, FrameData, m_fd);
        chk({tag, "_frames_done"}, {112'd0, frames_done}, {112'd0, m_done});
        chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
        chk({tag, "_err_par"}, {127'd0, err_par}, {127'd0, m_err_par});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d [4];
        int hc, lc, hc2, lc2, wc;

        tbl[0].d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tbl[0].hdr = mk_hdr(31'd3, tbl[0].d);   tbl[0].load = 1; tbl[0].strobe = 20'h00008; tbl[0].err_idx = 0;
        tbl[1].d = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        tbl[1].hdr = mk_hdr(31'd25, tbl[1].d);  tbl[1].load = 0; tbl[1].strobe = 20'h00000; tbl[1].err_idx = 1;
        tbl[2].d = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000};
        tbl[2].hdr = mk_hdr(31'd0, tbl[2].d);   tbl[2].load = 1; tbl[2].strobe = 20'h00001; tbl[2].err_idx = 1;
        tbl[3].d = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        tbl[3].hdr = mk_hdr(31'd19, tbl[3].d);  tbl[3].load = 1; tbl[3].strobe = 20'h80000; tbl[3].err_idx = 1;
        tbl[4].d = '{32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008};
        tbl[4].hdr = mk_hdr(31'd20, tbl[4].d);  tbl[4].load = 0; tbl[4].strobe = 20'h00000; tbl[4].err_idx = 1;
        tbl[5].d = '{32'h0C0C0C0C, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
        tbl[5].hdr = mk_hdr(31'h00ABCD0C, tbl[5].d); tbl[5].load = 1; tbl[5].strobe = 20'h01000; tbl[5].err_idx = 1;
        tbl[6].d = '{32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA};
        tbl[6].hdr = mk_hdr(31'h000000FF, tbl[6].d); tbl[6].load = 0; tbl[6].strobe = 20'h00000; tbl[6].err_idx = 1;

        RST = 1'b1; cfg_valid = 1'b0; cfg_data = 32'd0;
        m_fd = '0; m_done = '0; m_err_par = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_framedata", FrameData, 128'd0);
        chk("rst_strobe", {108'd0, FrameStrobe}, 128'd0);
        chk("rst_frames_done", {112'd0, frames_done}, 128'd0);
        chk("rst_flags", {125'd0, busy, err_idx, err_par}, 128'd0);
        chk("rst_ready", {127'd0, cfg_ready}, 128'd1);
        mon_en = 1;

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].hdr, tbl[i].d, tbl[i].load, tbl[i].strobe, 1'b0, hc, lc);
            settle_and_check("vec", tbl[i].err_idx);
        end

        // valid gaps between data words must hold the row counter
        d = '{32'h70707070, 32'h71717171, 32'h72727272, 32'h73737373};
        send_word(mk_hdr(31'd7, d), wc);
        send_word(d[0], wc);
        cfg_valid = 1'b0;
        cfg_data  = 32'hBAD0BAD0;
        repeat (2) @(posedge CLK);
        #1;
        chk("gap_busy", {127'd0, busy}, 128'd1);
        chk("gap_no_strobe", {108'd0, FrameStrobe}, 128'd0);
        send_word(d[1], wc);
        send_word(d[2], wc);
        send_word(d[3], lc);
        for (int i = 0; i < 4; i++) m_fd[32*i +: 32] = d[i];
        m_done++;
        sb_q.push_back('{strobe: 20'h00080, fd: m_fd, done: m_done, cycle: lc});
        cfg_valid = 1'b0;
        settle_and_check("gap", 1'b1);

        // reset in the middle of a frame drops it
        d = '{32'h50505050, 32'h51515151, 32'h52525252, 32'h53535353};
        send_word(mk_hdr(31'd5, d), wc);
        send_word(d[0], wc);
        send_word(d[1], wc);
        cfg_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_fd = '0; m_done = '0; m_err_par = 1'b0;
        chk("midrst_framedata", FrameData, 128'd0);
        chk("midrst_frames_done", {112'd0, frames_done}, 128'd0);
        chk("midrst_flags", {125'd0, busy, err_idx, err_par}, 128'd0);
        send_frame(mk_hdr(31'd5, d), d, 1'b1, 20'h00020, 1'b0, hc, lc);
        settle_and_check("after_rst", 1'b0);

        // back-to-back frames with valid held high
        d = '{32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004};
        send_frame(mk_hdr(31'd1, d), d, 1'b1, 20'h00002, 1'b1, hc, lc);
        d = '{32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004};
        send_frame(mk_hdr(31'd2, d), d, 1'b1, 20'h00004, 1'b0, hc2, lc2);
        chk("b2b_next_header_cycle", 128'(hc2), 128'(lc + 2));
        settle_and_check("b2b", 1'b0);

        d = '{32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000};
`ifdef FRAME_CONFIG_LOADER_PARITY_EN
        send_frame(32'h00000004, d, 1'b1, 20'h00000, 1'b0, hc, lc);
        m_err_par = 1'b1;
        settle_and_check("par_bad", 1'b0);
        send_frame(32'h80000004, d, 1'b1, 20'h00010, 1'b0, hc, lc);
        settle_and_check("par_good", 1'b0);
`else
        send_frame(32'h00000004, d, 1'b1, 20'h00010, 1'b0, hc, lc);
        settle_and_check("par_ignored", 1'b0);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
